// File: rtl/uart_tx_fifo_gen2.sv
// UART transmitter with an input FIFO, internal bit-rate prescaler, optional parity
// and one or two stop bits; queued words go out back-to-back with no idle gap.
module uart_tx_fifo_gen2 #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PRESC_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESC_WIDTH-1:0]        Prescale,
  input  logic [DATA_WIDTH-1:0]         TX_IN_P,
  input  logic                          TX_IN_V,
  output logic                          TX_IN_R,
  output logic                          TX_OUT_S,
  output logic                          TX_OUT_V,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LVL
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam int unsigned PW = PRESC_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tx_s_q, tx_s_d;
  logic                  tx_v_q, tx_v_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         lvl_q, lvl_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic bit_end;

  assign TX_IN_R  = (lvl_q != LW'(FIFO_DEPTH));
  assign TX_OUT_S = tx_s_q;
  assign TX_OUT_V = tx_v_q;
  assign FIFO_LVL = lvl_q;

  // Frame sequencing, FIFO bookkeeping and next line value
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    presc_d    = presc_q;
    bit_d      = bit_q;
    stop_idx_d = stop_idx_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pop        = 1'b0;
    push       = TX_IN_V && TX_IN_R;
    bit_end    = (cnt_q == presc_q - PW'(1));
    cnt_d      = bit_end ? '0 : cnt_q + PW'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (lvl_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            state_d    = par_en_q ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) stop_idx_d = 1'b1;
          else if (lvl_q != '0)       pop = 1'b1;
          else                        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame start: take the FIFO head and freeze the line configuration
    if (pop) begin
      state_d   = S_START;
      cnt_d     = '0;
      data_d    = mem_q[rd_ptr_q];
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      stop2_d   = STOP2;
      presc_d   = (Prescale == '0) ? PW'(1) : Prescale;
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    lvl_d = lvl_q + LW'(push) - LW'(pop);

    case (state_d)
      S_START:  tx_s_d = 1'b0;
      S_DATA:   tx_s_d = data_d[bit_d];
      S_PARITY: tx_s_d = par_typ_d ? ~^data_d : ^data_d;
      default:  tx_s_d = 1'b1;
    endcase
    tx_v_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      presc_q    <= PW'(1);
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      tx_s_q     <= 1'b1;
      tx_v_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lvl_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_idx_q <= stop_idx_d;
      tx_s_q     <= tx_s_d;
      tx_v_q     <= tx_v_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lvl_q      <= lvl_d;
      if (push) mem_q[wr_ptr_q] <= TX_IN_P;
    end
  end

endmodule
